// File: rtl/taxi_sfp_led_pkg.sv
// Shared types for the SFP cage LED controller.
//   sfp_port_state_t : port classification, also driven out on stat_state
//   PHASE_W          : width of the blink phase counter (fast = bit 0, slow = MSB)

package taxi_sfp_led_pkg;

  typedef enum logic [1:0] {
    ABSENT  = 2'd0,
    FAULT   = 2'd1,
    NO_LINK = 2'd2,
    LINK_UP = 2'd3
  } sfp_port_state_t;

  localparam int PHASE_W = 3;

endpackage

// File: rtl/taxi_debounce.sv
// Two-flop synchronizer followed by a stability debouncer for one raw pin.
//   clk, rst : core clock, asynchronous active-high reset
//   in       : raw asynchronous pin
//   out      : debounced level; changes only after DEBOUNCE_CYCLES consecutive
//              synchronized samples that differ from the current output
// All flops (synchronizer and output) reset to RST_VAL, the pin's inactive level.

module taxi_debounce #(
  parameter int   DEBOUNCE_CYCLES = 1250000,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_0;
  logic             sync_1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_0 <= RST_VAL;
      sync_1 <= RST_VAL;
      out    <= RST_VAL;
      cnt    <= '0;
    end else begin
      sync_0 <= in;
      sync_1 <= sync_0;
      if (sync_1 == out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        out <= sync_1;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/taxi_sfp_led_ctrl.sv
// Per-cage SFP+ status monitor and LED driver.
//   clk, rst      : 125 MHz core clock, asynchronous active-high reset
//   sfp_npres     : raw module-present pin (active low)
//   sfp_tx_fault  : raw TX fault pin
//   sfp_los       : raw loss-of-signal pin
//   link_up       : PCS link status (clk domain)
//   act           : single-cycle frame activity pulse (clk domain)
//   sfp_led       : LED drive, active high
//   stat_present, stat_fault, stat_los : debounced pin status
//   stat_state    : port classification (sfp_port_state_t)
//
// state   | meaning
// ABSENT  | no module in the cage, LED off
// FAULT   | module reports TX fault, LED fast blink
// NO_LINK | module present, LOS or PCS down, LED slow blink
// LINK_UP | link good, LED on, dark/bright activity blink on traffic

module taxi_sfp_led_ctrl
  import taxi_sfp_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int BLINK_CYCLES    = 6250000,
  parameter int ACT_CYCLES      = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sfp_npres,
  input  logic       sfp_tx_fault,
  input  logic       sfp_los,
  input  logic       link_up,
  input  logic       act,
  output logic       sfp_led,
  output logic       stat_present,
  output logic       stat_fault,
  output logic       stat_los,
  output logic [1:0] stat_state
);

  localparam int BLINK_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam int ACT_W   = $clog2(2 * ACT_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [ACT_W-1:0]   ACT_HALF   = ACT_W'(ACT_CYCLES);
  localparam logic [ACT_W-1:0]   ACT_LAST   = ACT_W'(2 * ACT_CYCLES - 1);

  logic npres_db;
  logic fault_db;
  logic los_db;

  taxi_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_db_npres (
    .clk(clk), .rst(rst), .in(sfp_npres), .out(npres_db)
  );

  taxi_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db_fault (
    .clk(clk), .rst(rst), .in(sfp_tx_fault), .out(fault_db)
  );

  taxi_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_db_los (
    .clk(clk), .rst(rst), .in(sfp_los), .out(los_db)
  );

  // Free-running blink timebase; deliberately not restarted on state change.
  logic [BLINK_W-1:0] presc;
  logic [PHASE_W-1:0] phase;
  logic               blink_tick;

  assign blink_tick = (presc == BLINK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      phase <= '0;
    end else begin
      presc <= blink_tick ? '0 : presc + BLINK_W'(1);
      if (blink_tick) begin
        phase <= phase + PHASE_W'(1);
      end
    end
  end

  sfp_port_state_t state;
  sfp_port_state_t state_next;
  logic            led_next;
  logic            act_busy;
  logic [ACT_W-1:0] act_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ABSENT;
      sfp_led <= 1'b0;
    end else begin
      state   <= state_next;
      sfp_led <= led_next;
    end
  end

  always_comb begin
    state_next = LINK_UP;
    led_next   = 1'b0;

    if (npres_db) begin
      state_next = ABSENT;
    end else if (fault_db) begin
      state_next = FAULT;
    end else if (los_db || !link_up) begin
      state_next = NO_LINK;
    end

    case (state)
      FAULT:   led_next = phase[0];
      NO_LINK: led_next = phase[PHASE_W-1];
      LINK_UP: led_next = !(act_busy && (act_cnt < ACT_HALF));
      default: led_next = 1'b0;
    endcase
  end

  // Activity window: dark for the first ACT_CYCLES counts, lit for the second
  // half, then idle. Decisions use the current state so a coincident state
  // change and act pulse resolve against the pre-update state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_busy <= 1'b0;
      act_cnt  <= '0;
    end else if (state != LINK_UP) begin
      act_busy <= 1'b0;
      act_cnt  <= '0;
    end else if (act_busy) begin
      if (act_cnt == ACT_LAST) begin
        act_busy <= 1'b0;
        act_cnt  <= '0;
      end else begin
        act_cnt <= act_cnt + ACT_W'(1);
      end
    end else if (act) begin
      act_busy <= 1'b1;
    end
  end

  assign stat_present = ~npres_db;
  assign stat_fault   = fault_db;
  assign stat_los     = los_db;
  assign stat_state   = state;

endmodule

// File: tb/tb_taxi_sfp_led_ctrl.sv
// Self-checking bench for taxi_sfp_led_ctrl with a cycle-indexed behavioural model.

module tb_taxi_sfp_led_ctrl;

  localparam int DEB   = 4;
  localparam int BLINK = 8;
  localparam int ACT   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sfp_npres = 1'b1;
  logic       sfp_tx_fault = 1'b0;
  logic       sfp_los = 1'b1;
  logic       link_up = 1'b1;
  logic       act = 1'b0;
  logic       sfp_led;
  logic       stat_present;
  logic       stat_fault;
  logic       stat_los;
  logic [1:0] stat_state;

  taxi_sfp_led_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLINK), .ACT_CYCLES(ACT)
  ) dut (
    .clk(clk), .rst(rst), .sfp_npres(sfp_npres), .sfp_tx_fault(sfp_tx_fault),
    .sfp_los(sfp_los), .link_up(link_up), .act(act), .sfp_led(sfp_led),
    .stat_present(stat_present), .stat_fault(stat_fault), .stat_los(stat_los),
    .stat_state(stat_state)
  );

  always #4 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // e counts clock edges since reset release. Each raw pin is seen two edges
  // late; a debounced level flips after DEB consecutive late samples disagree.
  int   e;
  logic [1:0] pn_d, pf_d, pl_d;
  logic m_npres, m_fault, m_los;
  int   run_n, run_f, run_l;
  int   m_state;
  bit   m_led;
  bit   win;
  int   win_s;
  int   st_old, ws_old, ph_old;
  bit   win_old;

  function automatic int classify(input logic np, input logic f, input logic l, input logic lu);
    if (np) return 0;
    if (f) return 1;
    if (l || !lu) return 2;
    return 3;
  endfunction

  task automatic deb(input logic s, inout logic db, inout int run);
    if (s !== db) begin
      run++;
      if (run == DEB) begin
        db  = s;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic m_reset();
    e = 0;
    pn_d = 2'b11; pf_d = 2'b00; pl_d = 2'b11;
    m_npres = 1'b1; m_fault = 1'b0; m_los = 1'b1;
    run_n = 0; run_f = 0; run_l = 0;
    m_state = 0; m_led = 1'b0; win = 1'b0; win_s = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
      end else begin
        st_old  = m_state;
        win_old = win;
        ws_old  = win_s;
        e       = e + 1;
        ph_old  = ((e - 1) / BLINK) % 8;
        case (st_old)
          1:       m_led = (ph_old % 2) == 1;
          2:       m_led = ph_old >= 4;
          3:       m_led = !(win_old && ((e - 1 - ws_old) < ACT));
          default: m_led = 1'b0;
        endcase
        if (st_old != 3) win = 1'b0;
        else if (win_old) begin
          if (e - ws_old == 2 * ACT) win = 1'b0;
        end else if (act) begin
          win   = 1'b1;
          win_s = e;
        end
        m_state = classify(m_npres, m_fault, m_los, link_up);
        deb(pn_d[1], m_npres, run_n);
        deb(pf_d[1], m_fault, run_f);
        deb(pl_d[1], m_los,   run_l);
        pn_d = {pn_d[0], sfp_npres};
        pf_d = {pf_d[0], sfp_tx_fault};
        pl_d = {pl_d[0], sfp_los};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("sfp_led",      {31'd0, sfp_led},      {31'd0, m_led});
        chk("stat_present", {31'd0, stat_present}, {31'd0, ~m_npres});
        chk("stat_fault",   {31'd0, stat_fault},   {31'd0, m_fault});
        chk("stat_los",     {31'd0, stat_los},     {31'd0, m_los});
        chk("stat_state",   {30'd0, stat_state},   32'(m_state));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  bit exp_led [1:8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    chk_en = 1'b1;
    // 1: reset with idle pins
    cyc(3);
    chk("rst_led",   {31'd0, sfp_led},  32'd0);
    chk("rst_state", {30'd0, stat_state}, 32'd0);
    chk("rst_los",   {31'd0, stat_los}, 32'd1);
    rst = 1'b0;
    cyc(20);
    chk("idle_state", {30'd0, stat_state}, 32'd0);
    chk("idle_led",   {31'd0, sfp_led},    32'd0);

    // 2: module inserted
    sfp_npres = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      if (k == 5) chk("pres_lat5", {31'd0, stat_present}, 32'd0);
      if (k == 6) chk("pres_lat6", {31'd0, stat_present}, 32'd1);
      if (k == 6) chk("nolink_lat6", {30'd0, stat_state}, 32'd0);
      if (k == 7) chk("nolink_lat7", {30'd0, stat_state}, 32'd2);
    end
    cyc(70);

    // 3: short LOS glitch, then real LOS clear
    sfp_los = 1'b0;
    cyc(3);
    sfp_los = 1'b1;
    cyc(10);
    chk("los_glitch", {31'd0, stat_los}, 32'd1);
    sfp_los = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      if (k == 5) chk("los_lat5", {31'd0, stat_los}, 32'd1);
      if (k == 6) chk("los_lat6", {31'd0, stat_los}, 32'd0);
      if (k == 7) chk("up_lat7",  {30'd0, stat_state}, 32'd3);
      if (k == 8) chk("up_led8",  {31'd0, sfp_led}, 32'd1);
    end
    cyc(5);

    // 4: activity window, ignored retrigger, later retrigger; 5: fault aborts window
    act = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      cyc(1);
      act = 1'b0;
      if (k <= 8) chk("act_led", {31'd0, sfp_led}, {31'd0, exp_led[k]});
      if (k == 2 || k == 9) act = 1'b1;
      if (k == 6) sfp_tx_fault = 1'b1;
      if (k == 10) chk("act2_led10", {31'd0, sfp_led}, 32'd1);
      if (k == 11) chk("act2_led11", {31'd0, sfp_led}, 32'd0);
      if (k == 11) chk("fault_lat5", {31'd0, stat_fault}, 32'd0);
      if (k == 12) chk("fault_lat6", {31'd0, stat_fault}, 32'd1);
      if (k == 13) chk("fault_st7",  {30'd0, stat_state}, 32'd1);
      if (k == 13) chk("abort_led13", {31'd0, sfp_led}, 32'd0);
    end
    cyc(40);

    // 6: reset mid-blink and mid-debounce, then npres glitch
    sfp_tx_fault = 1'b0;
    cyc(2);
    #2 rst = 1'b1;
    #1;
    chk("arst_led",   {31'd0, sfp_led},      32'd0);
    chk("arst_state", {30'd0, stat_state},   32'd0);
    chk("arst_pres",  {31'd0, stat_present}, 32'd0);
    chk("arst_los",   {31'd0, stat_los},     32'd1);
    sfp_npres = 1'b1;
    sfp_los   = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    sfp_npres = 1'b0;
    cyc(3);
    sfp_npres = 1'b1;
    cyc(12);
    chk("glitch_pres", {31'd0, stat_present}, 32'd0);

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      cyc(1);
      act = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, sfp_npres ? 15 : 150) == 0) sfp_npres = ~sfp_npres;
      if ($urandom_range(0, sfp_tx_fault ? 20 : 200) == 0) sfp_tx_fault = ~sfp_tx_fault;
      if ($urandom_range(0, 40) == 0) sfp_los = ~sfp_los;
      if ($urandom_range(0, link_up ? 120 : 10) == 0) link_up = ~link_up;
      if (c == 2000) begin
        #2 rst = 1'b1;
        cyc(2);
        rst = 1'b0;
      end
    end

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/taxi_sfp_led_ctrl.md
Name: taxi_sfp_led_ctrl

Overview:
Per-cage SFP+ status monitor and LED driver. It sits inside fpga_core on the 125 MHz core clock and is instantiated once per cage. It synchronizes and debounces the raw module-present, TX-fault and LOS pins, combines them with the PCS link status to classify the port, and drives that cage's sfp_led with solid, blink or activity patterns.

Parameters:
DEBOUNCE_CYCLES, 1250000, consecutive stable cycles before a debounced input changes (10 ms at 125 MHz); minimum 2
BLINK_CYCLES, 6250000, prescaler period producing the blink tick (50 ms)
ACT_CYCLES, 2500000, length of each half of the activity blink (20 ms)

Ports:
clk  in  1  core clock, 125 MHz
rst  in  1  asynchronous active-high reset
sfp_npres  in  1  raw module-present pin, active low, asynchronous
sfp_tx_fault  in  1  raw TX fault pin, asynchronous
sfp_los  in  1  raw loss-of-signal pin, asynchronous
link_up  in  1  PCS block lock / link status, synchronous to clk
act  in  1  single-cycle RX or TX frame activity pulse, synchronous to clk
sfp_led  out  1  LED drive, active high
stat_present  out  1  debounced module present
stat_fault  out  1  debounced TX fault
stat_los  out  1  debounced LOS
stat_state  out  2  current port state (encoding below)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Every flop resets asynchronously.
- Reset values:
  - sfp_led=0, stat_present=0, stat_fault=0, stat_los=1, stat_state=ABSENT.
  - All counters reset to 0.
  - Synchronizer flops reset to the same inactive levels: npres=1, fault=0, los=1.
- Synchronizer: two flops per raw pin.
- Debounce (per input):
  - The counter increments while the synchronized value differs from the debounced value.
  - The counter clears to 0 on any cycle the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced value takes the synchronized value on the next edge and the counter clears.
  - Latency from a clean pin edge to the stat_* change: 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- State encoding: ABSENT=0, FAULT=1, NO_LINK=2, LINK_UP=3.
- State selection:
  - Next state is computed combinationally from the registered debounced values and link_up.
  - Priority: !present -> ABSENT; else fault -> FAULT; else (los or !link_up) -> NO_LINK; else LINK_UP.
  - The state register updates one cycle after its inputs change.
  - Any state can move to any state directly.
- Blink timebase:
  - The prescaler counts 0..BLINK_CYCLES-1 and emits tick on its terminal count, then wraps.
  - A 3-bit phase counter increments on tick and wraps 7->0.
  - fast = phase[0]; slow = phase[2].
  - The timebase is free-running and is not reset on state change.
- LED pattern by state (sfp_led is registered, 1 cycle after stat_state):
  - ABSENT: 0.
  - FAULT: fast.
  - NO_LINK: slow.
  - LINK_UP: 1, except during an activity window.
- Activity window:
  - act while in LINK_UP and the window is idle starts the window.
  - The LED is 0 for ACT_CYCLES cycles, then 1 for ACT_CYCLES cycles, then the window returns to idle.
  - act inside the window is ignored, so no retrigger occurs.
  - act in any other state is ignored.
  - Leaving LINK_UP aborts the window immediately: the counter clears and the window goes idle.
- Simultaneous events: a state change and act in the same cycle resolve against the current (pre-update) state register.
- Reset mid-operation returns all outputs to their reset values asynchronously. After reset deassertion, the stat outputs reflect the pins only after the full debounce latency.

Decomposition:
- Package taxi_sfp_led_pkg:
  - state enum sfp_port_state_t (ABSENT, FAULT, NO_LINK, LINK_UP).
  - Phase counter width constant (3).
- Sub-module taxi_debounce:
  - Parameters: DEBOUNCE_CYCLES, RST_VAL.
  - Ports: clk, rst, in, out.
  - Contains the 2-flop synchronizer plus the counter.
  - Instantiated three times.
- FSM, timebase and activity logic stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, ACT_CYCLES=3):
1. Reset, then pins idle (npres=1, los=1) -> sfp_led=0, stat_state=0, stat_los=1 throughout.
2. npres 1->0 at cycle 0 -> stat_present=1 at cycle 6, stat_state=2 at cycle 7. sfp_led follows slow: high for 32 cycles, low for 32 cycles.
3. Present, then los pulsed 0 for 3 cycles -> stat_los stays 1. los held 0 with link_up=1 -> stat_state=3 at +7, sfp_led=1 at +8.
4. LINK_UP, act pulsed at cycle 0 and again at cycle 2 -> sfp_led=0 for cycles 2..4, 1 for cycles 5..7. The second pulse has no effect; a new act at cycle 9 retriggers.
5. LINK_UP, tx_fault raised -> stat_state=1 after 6+1 cycles. sfp_led toggles every 8 cycles. An activity window in progress is aborted.
6. rst asserted mid-blink and mid-debounce -> sfp_led=0 and stat_state=0 in the same cycle. After release, a 3-cycle npres glitch leaves stat_present=0.
